uart_cmd_parser: RTL and testbench

Command front end between the UART receiver/transmitter pair and the ALU. It decodes a byte-stream protocol of command header bytes plus optional payload bytes into registered operands A/B and an opcode, and issues a one-cycle `o_valid` to the ALU. It returns the ALU result over the UART transmitter via a start/done handshake. It adds payload timeout, unknown-command rejection and overrun detection, and is parametrised in data width, opcode width and timeout depth.

---
 rtl/uart_cmd_parser_pkg.sv | 18 +
 rtl/uart_cmd_parser_if.sv | 26 ++
 rtl/uart_cmd_parser_timeout_counter.sv | 20 ++
 rtl/uart_cmd_parser.sv | 100 ++++++++++
 tb/tb_uart_cmd_parser.sv | 137 +++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_pkg: command codes, FSM/error encodings and timeout counter sizing.
package uart_cmd_pkg;
  localparam logic [7:0] CMD_LOAD_A  = 8'h01;
  localparam logic [7:0] CMD_LOAD_B  = 8'h02;
  localparam logic [7:0] CMD_LOAD_OP = 8'h04;
  localparam logic [7:0] CMD_READ    = 8'h08;
  typedef enum logic [1:0] {IDLE, PAYLOAD, TX_START, TX_WAIT} state_e;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BAD_CMD = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_OVERRUN = 2'b11
  } err_e;
  typedef enum logic [1:0] {TGT_A, TGT_B, TGT_OP} tgt_e;
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: byte stream, ALU and transmitter signals of the command parser.
interface uart_cmd_parser_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_valid;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_err;
  logic [1:0]         o_err_code;
  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_valid, o_tx_start, o_tx_data, o_err, o_err_code
  );
  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_op, o_valid, o_tx_start, o_tx_data, o_err, o_err_code
  );
endinterface

// File: rtl/uart_cmd_parser_timeout_counter.sv
// cmd_timeout_counter: counts cycles while enabled; expired on the last allowed cycle.
module cmd_timeout_counter
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes header/payload byte frames into ALU operands and
// returns ALU results to the UART transmitter, flagging bad, late and overrun bytes.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic              clk,
  input logic              i_rst_n,
  uart_cmd_parser_if.slave bus
);
  state_e             state_q;
  tgt_e               tgt_q;
  err_e               err_code_q;
  logic [NB_DATA-1:0] a_q, b_q, tx_data_q;
  logic [NB_OP-1:0]   op_q;
  logic               valid_q, pend_q, tx_start_q, err_q, expired;
  logic               hdr_a, hdr_b, hdr_op, hdr_rd;
  assign hdr_a  = bus.i_rx_data == NB_DATA'(CMD_LOAD_A);
  assign hdr_b  = bus.i_rx_data == NB_DATA'(CMD_LOAD_B);
  assign hdr_op = bus.i_rx_data == NB_DATA'(CMD_LOAD_OP);
  assign hdr_rd = bus.i_rx_data == NB_DATA'(CMD_READ);
  cmd_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .clr     (state_q != PAYLOAD),
    .en      (state_q == PAYLOAD),
    .expired (expired)
  );
  // pend_q delays o_valid one cycle so it follows the visible o_op update
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tgt_q      <= TGT_A;
      err_code_q <= ERR_NONE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= pend_q;
      pend_q     <= 1'b0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: if (bus.i_rx_done) begin
          if (hdr_a || hdr_b || hdr_op) begin
            tgt_q   <= hdr_a ? TGT_A : hdr_b ? TGT_B : TGT_OP;
            state_q <= PAYLOAD;
          end else if (hdr_rd) begin
            tx_data_q  <= bus.i_alu_result;
            tx_start_q <= 1'b1;
            state_q    <= TX_START;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= ERR_BAD_CMD;
          end
        end
        PAYLOAD: if (bus.i_rx_done) begin
          if (tgt_q == TGT_A) a_q <= bus.i_rx_data;
          if (tgt_q == TGT_B) b_q <= bus.i_rx_data;
          if (tgt_q == TGT_OP) op_q <= bus.i_rx_data[NB_OP-1:0];
          pend_q  <= tgt_q == TGT_OP;
          state_q <= IDLE;
        end else if (expired) begin
          err_q      <= 1'b1;
          err_code_q <= ERR_TIMEOUT;
          state_q    <= IDLE;
        end
        TX_START: begin
          if (bus.i_rx_done) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_OVERRUN;
          end
          state_q <= TX_WAIT;
        end
        TX_WAIT: begin
          if (bus.i_rx_done) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_OVERRUN;
          end
          if (bus.i_tx_done) state_q <= IDLE;
        end
      endcase
    end
  assign bus.o_data_a   = a_q;
  assign bus.o_data_b   = b_q;
  assign bus.o_op       = op_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = err_code_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frame scenarios with hand-computed expectations.
module tb_uart_cmd_parser;
  logic clk, i_rst_n;
  int errors = 0;
  int checks = 0;
  uart_cmd_parser_if #(.NB_DATA(8), .NB_OP(6)) bus ();
  uart_cmd_parser #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask
  task automatic test_reset;
    i_rst_n = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_alu_result = '0;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_data_a !== 8'h00) begin errors++; $display("FAIL reset_a: got %h want 00", bus.o_data_a); end
    checks++; if (bus.o_op !== 6'h00) begin errors++; $display("FAIL reset_op: got %h want 00", bus.o_op); end
    checks++; if ({bus.o_valid, bus.o_tx_start, bus.o_err, bus.o_err_code} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {bus.o_valid, bus.o_tx_start, bus.o_err, bus.o_err_code}); end
    i_rst_n = 1'b1;
  endtask
  task automatic test_load;
    send_byte(8'h01); send_byte(8'h05);
    checks++; if (bus.o_data_a !== 8'h05) begin errors++; $display("FAIL load_a: got %h want 05", bus.o_data_a); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL load_a_novalid: got %b want 0", bus.o_valid); end
    send_byte(8'h02); send_byte(8'h03);
    checks++; if (bus.o_data_b !== 8'h03) begin errors++; $display("FAIL load_b: got %h want 03", bus.o_data_b); end
    send_byte(8'h04); send_byte(8'h20);
    checks++; if (bus.o_op !== 6'h20) begin errors++; $display("FAIL load_op: got %h want 20", bus.o_op); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b want 0", bus.o_valid); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL valid_pulse: got %b want 1", bus.o_valid); end
    checks++; if ({bus.o_data_a, bus.o_data_b} !== 16'h0503) begin errors++; $display("FAIL valid_operands: got %h want 0503", {bus.o_data_a, bus.o_data_b}); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL valid_single: got %b want 0", bus.o_valid); end
  endtask
  task automatic test_bad_cmd;
    send_byte(8'h55);
    checks++; if ({bus.o_err, bus.o_err_code} !== 3'b101) begin errors++; $display("FAIL bad_cmd_err: got %b want 101", {bus.o_err, bus.o_err_code}); end
    @(negedge clk);
    checks++; if ({bus.o_err, bus.o_err_code} !== 3'b001) begin errors++; $display("FAIL bad_cmd_hold: got %b want 001", {bus.o_err, bus.o_err_code}); end
    send_byte(8'h01); send_byte(8'hAA);
    checks++; if (bus.o_data_a !== 8'hAA) begin errors++; $display("FAIL bad_cmd_next: got %h want aa", bus.o_data_a); end
  endtask
  task automatic test_back_to_back;
    @(negedge clk); bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h01;
    @(negedge clk); bus.i_rx_data = 8'h44;
    @(negedge clk); bus.i_rx_data = 8'h02;
    @(negedge clk); bus.i_rx_data = 8'h66;
    @(negedge clk); bus.i_rx_done = 1'b0;
    checks++; if ({bus.o_data_a, bus.o_data_b} !== 16'h4466) begin errors++; $display("FAIL b2b_ab: got %h want 4466", {bus.o_data_a, bus.o_data_b}); end
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL b2b_noerr: got %b want 0", bus.o_err); end
  endtask
  task automatic test_timeout;
    send_byte(8'h02);
    repeat (15) @(negedge clk);
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", bus.o_err); end
    @(negedge clk);
    checks++; if ({bus.o_err, bus.o_err_code} !== 3'b110) begin errors++; $display("FAIL timeout_err: got %b want 110", {bus.o_err, bus.o_err_code}); end
    checks++; if (bus.o_data_b !== 8'h66) begin errors++; $display("FAIL timeout_b_kept: got %h want 66", bus.o_data_b); end
    send_byte(8'h02);
    repeat (13) @(negedge clk);
    send_byte(8'h5A);
    checks++; if (bus.o_data_b !== 8'h5A || bus.o_err !== 1'b0) begin errors++; $display("FAIL payload_c15: got b=%h err=%b want b=5a err=0", bus.o_data_b, bus.o_err); end
    send_byte(8'h02);
    repeat (14) @(negedge clk);
    send_byte(8'h77);
    checks++; if (bus.o_data_b !== 8'h77 || bus.o_err !== 1'b0) begin errors++; $display("FAIL payload_c16: got b=%h err=%b want b=77 err=0", bus.o_data_b, bus.o_err); end
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL payload_c16_after: got %b want 0", bus.o_err); end
  endtask
  task automatic test_read;
    bus.i_alu_result = 8'h7E;
    send_byte(8'h08);
    bus.i_alu_result = 8'h99;
    checks++; if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h7E) begin errors++; $display("FAIL read_start: got start=%b data=%h want 1 7e", bus.o_tx_start, bus.o_tx_data); end
    @(negedge clk);
    checks++; if (bus.o_tx_start !== 1'b0) begin errors++; $display("FAIL read_start_single: got %b want 0", bus.o_tx_start); end
    send_byte(8'h33);
    checks++; if ({bus.o_err, bus.o_err_code} !== 3'b111) begin errors++; $display("FAIL overrun: got %b want 111", {bus.o_err, bus.o_err_code}); end
    checks++; if (bus.o_tx_data !== 8'h7E) begin errors++; $display("FAIL tx_data_hold: got %h want 7e", bus.o_tx_data); end
    @(negedge clk); bus.i_tx_done = 1'b1;
    @(negedge clk); bus.i_tx_done = 1'b0;
    send_byte(8'h01); send_byte(8'h11);
    checks++; if (bus.o_data_a !== 8'h11) begin errors++; $display("FAIL after_tx: got %h want 11", bus.o_data_a); end
    send_byte(8'h08);
    @(negedge clk);
    @(negedge clk); bus.i_tx_done = 1'b1; bus.i_rx_done = 1'b1; bus.i_rx_data = 8'h01;
    @(negedge clk); bus.i_tx_done = 1'b0; bus.i_rx_done = 1'b0;
    checks++; if ({bus.o_err, bus.o_err_code} !== 3'b111) begin errors++; $display("FAIL overrun_same: got %b want 111", {bus.o_err, bus.o_err_code}); end
    send_byte(8'h02); send_byte(8'h21);
    checks++; if (bus.o_data_b !== 8'h21) begin errors++; $display("FAIL after_same: got %h want 21", bus.o_data_b); end
  endtask
  task automatic test_reset_mid;
    send_byte(8'h04);
    @(negedge clk);
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if ({bus.o_data_a, bus.o_data_b, bus.o_tx_data} !== 24'h0) begin errors++; $display("FAIL midrst_regs: got %h want 000000", {bus.o_data_a, bus.o_data_b, bus.o_tx_data}); end
    checks++; if ({bus.o_op, bus.o_valid, bus.o_tx_start, bus.o_err, bus.o_err_code} !== 11'h0) begin errors++; $display("FAIL midrst_ctl: got %h want 000", {bus.o_op, bus.o_valid, bus.o_tx_start, bus.o_err, bus.o_err_code}); end
    @(negedge clk); i_rst_n = 1'b1;
    send_byte(8'hC5);
    checks++; if ({bus.o_err, bus.o_err_code} !== 3'b101) begin errors++; $display("FAIL midrst_idle: got %b want 101", {bus.o_err, bus.o_err_code}); end
    send_byte(8'h04); send_byte(8'h3F);
    checks++; if (bus.o_op !== 6'h3F) begin errors++; $display("FAIL op_3f: got %h want 3f", bus.o_op); end
    send_byte(8'h04); send_byte(8'hC5);
    checks++; if (bus.o_op !== 6'h05) begin errors++; $display("FAIL op_trunc: got %h want 05", bus.o_op); end
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL op_refire: got %b want 1", bus.o_valid); end
    send_byte(8'h04); send_byte(8'hFF);
    checks++; if (bus.o_op !== 6'h3F) begin errors++; $display("FAIL op_ff: got %h want 3f", bus.o_op); end
  endtask
  initial begin
    test_reset;
    test_load;
    test_bad_cmd;
    test_back_to_back;
    test_timeout;
    test_read;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
